// File: rtl/l15_data_bank_ctrl_if.sv
// ============================================================================
// Module      : l15_data_bank_ctrl_if
// Description : Requester and data-bank signal bundle for l15_data_bank_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l15_data_bank_ctrl_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6
);
    logic                    init_done_o;
    logic                    rd_req_i;
    logic [ADDR_WIDTH-1:0]   rd_addr_i;
    logic                    rd_gnt_o;
    logic                    rd_rvalid_o;
    logic [DATA_WIDTH-1:0]   rd_rdata_o;
    logic                    wr_req_i;
    logic [ADDR_WIDTH-1:0]   wr_addr_i;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic                    wr_gnt_o;
    logic                    ram_req_o;
    logic                    ram_write_o;
    logic [ADDR_WIDTH-1:0]   ram_addr_o;
    logic [DATA_WIDTH-1:0]   ram_wdata_o;
    logic [DATA_WIDTH/8-1:0] ram_be_o;
    logic [DATA_WIDTH-1:0]   ram_rdata_i;

    // Controller side
    modport slave (
        output init_done_o,
        input  rd_req_i, rd_addr_i,
        output rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        input  wr_req_i, wr_addr_i, wr_data_i,
        output wr_gnt_o,
        output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_be_o,
        input  ram_rdata_i
    );

    // Requesters and bank side
    modport master (
        input  init_done_o,
        output rd_req_i, rd_addr_i,
        input  rd_gnt_o, rd_rvalid_o, rd_rdata_o,
        output wr_req_i, wr_addr_i, wr_data_i,
        input  wr_gnt_o,
        input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_be_o,
        output ram_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/l15_data_bank_ctrl.sv
// ============================================================================
// Module      : l15_data_bank_ctrl
// Description : L1.5 I-cache data bank sequencer: post-reset zero fill, then
//               write-priority arbitration with a bounded read starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l15_data_bank_ctrl #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 6,
    parameter int MAX_WR_STREAK = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    l15_data_bank_ctrl_if.slave     bus
);
    localparam int                    BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [3:0]            MAX_STREAK = 4'(MAX_WR_STREAK);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic [3:0]              r_streak;
    logic                    r_rvalid;
    logic                    r_init_done;

    logic                    w_run;
    logic                    w_streak_full;
    logic                    w_rd_gnt;
    logic                    w_wr_gnt;
    logic                    w_ram_req;
    logic                    w_ram_write;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_ram_wdata;
    logic [BE_WIDTH-1:0]     w_ram_be;

    // Grants are gated by rst so the bank sees no request while reset is held
    always_comb begin
        w_run         = (r_state == ST_RUN) && !rst;
        w_streak_full = (r_streak == MAX_STREAK);
        w_wr_gnt      = w_run && bus.wr_req_i && !(bus.rd_req_i && w_streak_full);
        w_rd_gnt      = w_run && bus.rd_req_i && (!bus.wr_req_i || w_streak_full);
    end

    always_comb begin
        w_ram_req   = 1'b0;
        w_ram_write = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = bus.wr_data_i;
        w_ram_be    = '0;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                w_ram_req   = 1'b1;
                w_ram_write = 1'b1;
                w_ram_addr  = r_init_cnt;
                w_ram_wdata = '0;
                w_ram_be    = '1;
            end else begin
                w_ram_req   = w_rd_gnt | w_wr_gnt;
                w_ram_write = w_wr_gnt;
                w_ram_addr  = w_wr_gnt ? bus.wr_addr_i : bus.rd_addr_i;
                w_ram_be    = w_wr_gnt ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_streak    <= 4'd0;
            r_rvalid    <= 1'b0;
            r_init_done <= (INIT_ON_RESET == 0);
        end else begin
            r_rvalid <= w_rd_gnt;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Streak counts only writes that made a waiting read wait longer
                    if (!bus.rd_req_i || w_rd_gnt) begin
                        r_streak <= 4'd0;
                    end else if (w_wr_gnt && !w_streak_full) begin
                        r_streak <= r_streak + 4'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.init_done_o = r_init_done;
    assign bus.rd_gnt_o    = w_rd_gnt;
    assign bus.wr_gnt_o    = w_wr_gnt;
    assign bus.rd_rvalid_o = r_rvalid;
    assign bus.rd_rdata_o  = bus.ram_rdata_i;
    assign bus.ram_req_o   = w_ram_req;
    assign bus.ram_write_o = w_ram_write;
    assign bus.ram_addr_o  = w_ram_addr;
    assign bus.ram_wdata_o = w_ram_wdata;
    assign bus.ram_be_o    = w_ram_be;

endmodule

`default_nettype wire

// File: tb/tb_l15_data_bank_ctrl.sv
// ============================================================================
// Module      : tb_l15_data_bank_ctrl
// Description : Directed self-checking bench for l15_data_bank_ctrl with a
//               behavioural single-port bank attached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l15_data_bank_ctrl;
    localparam int DW  = 128;
    localparam int AW  = 6;
    localparam int BEW = DW / 8;

    logic clk;
    logic rst;
    logic preset;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    l15_data_bank_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    l15_data_bank_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .MAX_WR_STREAK (4),
        .INIT_ON_RESET (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: one access per cycle, read data registered
    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= {4{32'hDEADBEEF}};
        end else if (bif.ram_req_o) begin
            if (bif.ram_write_o) begin
                for (int b = 0; b < BEW; b++)
                    if (bif.ram_be_o[b]) mem[bif.ram_addr_o][8*b +: 8] <= bif.ram_wdata_o[8*b +: 8];
            end else begin
                rdata_q <= mem[bif.ram_addr_o];
            end
        end
    end
    assign bif.ram_rdata_i = rdata_q;

    task automatic chk(input string tag, input logic [DW+31:0] obs, input logic [DW+31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] pat_a5;
        logic [DW-1:0] pat_wr;
        int            reads;
        int            writes;
        logic          prev_rd;
        logic          exp_rd;

        vectors     = 0;
        miscompares = 0;
        pat_a5      = {BEW{8'hA5}};
        pat_wr      = {4{32'h1234_5678}};
        rdata_q     = '0;
        preset      = 1'b1;
        rst         = 1'b1;
        bif.rd_req_i  = 1'b1;
        bif.rd_addr_i = 6'd17;
        bif.wr_req_i  = 1'b1;
        bif.wr_addr_i = 6'd9;
        bif.wr_data_i = pat_wr;

        // Reset state
        #1;
        chk("rst_outputs", {bif.ram_req_o, bif.rd_gnt_o, bif.wr_gnt_o, bif.init_done_o, bif.rd_rvalid_o},
            {5'b00000});
        next();
        next();
        preset = 1'b0;
        next();
        rst = 1'b0;

        // Zero fill: addresses 0..63, no grants
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clk);
            chk($sformatf("init_ctl[%0d]", i),
                {bif.ram_req_o, bif.ram_write_o, bif.rd_gnt_o, bif.wr_gnt_o, bif.init_done_o, bif.ram_be_o},
                {5'b11000, 16'hFFFF});
            chk($sformatf("init_addr[%0d]", i), {bif.ram_wdata_o, bif.ram_addr_o}, {128'd0, 6'(i)});
            next();
        end
        bif.wr_req_i = 1'b0;
        @(negedge clk);
        chk("init_done_cycle64", {bif.init_done_o, bif.rd_gnt_o, bif.wr_gnt_o}, 3'b110);
        chk("first_read_drive", {bif.ram_req_o, bif.ram_write_o, bif.ram_addr_o, bif.ram_be_o},
            {2'b10, 6'd17, 16'h0000});
        next();
        bif.rd_req_i = 1'b0;
        @(negedge clk);
        chk("read17_zero", {bif.rd_rvalid_o, bif.rd_rdata_o}, {1'b1, 128'd0});
        chk("idle_no_req", bif.ram_req_o, 1'b0);

        // Read-after-write on address 5
        next();
        bif.wr_req_i  = 1'b1;
        bif.wr_addr_i = 6'd5;
        bif.wr_data_i = pat_a5;
        @(negedge clk);
        chk("raw_wr_drive", {bif.wr_gnt_o, bif.ram_req_o, bif.ram_write_o, bif.ram_addr_o, bif.ram_be_o, bif.ram_wdata_o},
            {3'b111, 6'd5, 16'hFFFF, pat_a5});
        next();
        bif.wr_req_i  = 1'b0;
        bif.rd_req_i  = 1'b1;
        bif.rd_addr_i = 6'd5;
        @(negedge clk);
        chk("raw_rd_gnt", {bif.rd_gnt_o, bif.rd_rvalid_o}, 2'b10);
        next();
        bif.rd_req_i = 1'b0;
        @(negedge clk);
        chk("raw_rdata", {bif.rd_rvalid_o, bif.rd_rdata_o}, {1'b1, pat_a5});

        // Contention: 4 writes then 1 read, repeating
        next();
        bif.rd_req_i  = 1'b1;
        bif.rd_addr_i = 6'd5;
        bif.wr_req_i  = 1'b1;
        bif.wr_addr_i = 6'd40;
        bif.wr_data_i = pat_wr;
        reads   = 0;
        writes  = 0;
        prev_rd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_rd = ((k % 5) == 4);
            @(negedge clk);
            chk($sformatf("streak_gnt[%0d]", k), {bif.rd_gnt_o, bif.wr_gnt_o, bif.rd_rvalid_o},
                {exp_rd, !exp_rd, prev_rd});
            if (prev_rd) chk($sformatf("streak_rdata[%0d]", k), bif.rd_rdata_o, pat_a5);
            if (bif.rd_gnt_o) reads++;
            if (bif.wr_gnt_o) writes++;
            prev_rd = exp_rd;
            next();
        end
        bif.rd_req_i = 1'b0;
        bif.wr_req_i = 1'b0;
        @(negedge clk);
        chk("streak_counts", {reads[7:0], writes[7:0]}, {8'd4, 8'd16});
        chk("streak_last_rvalid", bif.rd_rvalid_o, 1'b1);

        // Fill 0..7 with distinct lines, then stream reads
        for (int i = 0; i < 8; i++) begin
            next();
            bif.wr_req_i  = 1'b1;
            bif.wr_addr_i = 6'(i);
            bif.wr_data_i = {BEW{8'(8'h11 * (i + 1))}};
        end
        next();
        bif.wr_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bif.rd_req_i  = 1'b1;
            bif.rd_addr_i = 6'(i);
            @(negedge clk);
            chk($sformatf("stream_gnt[%0d]", i), {bif.rd_gnt_o, bif.rd_rvalid_o}, {1'b1, (i > 0)});
            if (i > 0) chk($sformatf("stream_data[%0d]", i - 1), bif.rd_rdata_o, {BEW{8'(8'h11 * i)}});
            next();
        end
        bif.rd_req_i = 1'b0;
        @(negedge clk);
        chk("stream_data[7]", {bif.rd_rvalid_o, bif.rd_rdata_o}, {1'b1, {BEW{8'h88}}});
        next();
        @(negedge clk);
        chk("stream_end", bif.rd_rvalid_o, 1'b0);

        // Reset in the cycle after a read grant
        next();
        bif.rd_req_i  = 1'b1;
        bif.rd_addr_i = 6'd3;
        @(negedge clk);
        chk("midread_gnt", bif.rd_gnt_o, 1'b1);
        next();
        chk("midread_rvalid_pre", bif.rd_rvalid_o, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("midread_rvalid_rst", {bif.rd_rvalid_o, bif.ram_req_o, bif.rd_gnt_o, bif.init_done_o}, 4'b0000);
        next();
        chk("rst_held_quiet", {bif.ram_req_o, bif.rd_gnt_o, bif.wr_gnt_o}, 3'b000);
        rst = 1'b0;

        // Reset during init at address 30, then a full restart
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            chk($sformatf("init1_addr[%0d]", i), {bif.ram_req_o, bif.ram_addr_o}, {1'b1, 6'(i)});
            if (i < 30) next();
        end
        #1;
        rst = 1'b1;
        #1;
        chk("init_rst_quiet", {bif.ram_req_o, bif.init_done_o}, 2'b00);
        next();
        rst = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clk);
            chk($sformatf("init2[%0d]", i), {bif.ram_req_o, bif.ram_write_o, bif.init_done_o, bif.rd_gnt_o, bif.ram_addr_o},
                {4'b1100, 6'(i)});
            next();
        end
        @(negedge clk);
        chk("init2_done", {bif.init_done_o, bif.rd_gnt_o, bif.ram_addr_o}, {2'b11, 6'd3});
        next();
        bif.rd_req_i = 1'b0;
        @(negedge clk);
        chk("init2_read3_zero", {bif.rd_rvalid_o, bif.rd_rdata_o}, {1'b1, 128'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
